diff_scheduler: RTL and testbench
=================================

DIFF_SCHEDULER -- requirements
Module: diff_scheduler

Interface
REQ-001 The block SHALL have parameter AXIS_TDATA_WIDTH, default 16, giving the sample width on all streams.
REQ-002 The block SHALL have parameter PIPE_DEPTH, default 2: the beat offset between a forwarded sample and the differentiator result returned with it.
REQ-003 The block SHALL have parameter SETTLE, default 6: the number of results suppressed after every channel switch.
REQ-004 aclk  in  1  single clock; all logic rising-edge.
REQ-005 aresetn  in  1  reset, asynchronous assert, active-low.
REQ-006 S0_AXIS_tvalid/S0_AXIS_tdata/S0_AXIS_tready  in/in/out  1/W/1  channel-0 sample stream.
REQ-007 S1_AXIS_tvalid/S1_AXIS_tdata/S1_AXIS_tready  in/in/out  1/W/1  channel-1 sample stream.
REQ-008 D_AXIS_tvalid/D_AXIS_tdata/D_AXIS_tready  out/out/in  1/W/1  samples to the shared differentiator.
REQ-009 R_AXIS_tvalid/R_AXIS_tdata  in/in  1/W  differentiator result, valid in the same cycle as the beat it accompanies.
REQ-010 M0_AXIS_tvalid/M0_AXIS_tdata and M1_AXIS_tvalid/M1_AXIS_tdata  out/out  1/W  per-channel results, registered.
REQ-011 cfg_burst  in  8  maximum beats per grant; value 0 SHALL be treated as 1.
REQ-012 grant  out  1  currently served channel; busy  out  1  high in CH0/CH1.

Function
REQ-013 The FSM SHALL have states IDLE, CH0 and CH1, and SHALL hold a last-served pointer (reset 1) plus an 8-bit beat counter.
REQ-014 In IDLE, the block SHALL move to CH0 if only S0 is valid, to CH1 if only S1 is valid, and to the channel other than last-served if both are valid.
REQ-015 In CHx, the block SHALL combinationally route Sx_tdata/tvalid to D_AXIS and D_AXIS_tready to Sx_tready; the other channel's tready SHALL be 0; in IDLE all S tready and D_AXIS_tvalid SHALL be 0.
REQ-016 An accepted beat (D_AXIS_tvalid and D_AXIS_tready) SHALL increment the beat counter.
REQ-017 CHx SHALL be left after the accepted beat that makes counter equal max(cfg_burst,1), or in any cycle Sx_tvalid is 0 with no beat.
REQ-018 On leaving CHx, the block SHALL set last-served to x and clear the counter; the next state SHALL be the other channel if that channel is valid, CHx again if only Sx is valid, otherwise IDLE.
REQ-019 A mid-grant cfg_burst change SHALL take effect at the next comparison; a counter already at or above the new limit SHALL end the grant at the next accepted beat.
REQ-020 A switch SHALL occur when a grant is given to a channel different from the channel of the previous accepted beat; on the first grant after reset it SHALL count as a switch; on a switch, the settle counter SHALL load SETTLE.
REQ-021 Each accepted beat SHALL push tag {channel, settle_active} into a PIPE_DEPTH-deep tag line, and decrement the settle counter if it is nonzero.
REQ-022 The tag line SHALL shift only on accepted beats; reset contents SHALL be settle_active=1.
REQ-023 The result in a cycle where R_AXIS_tvalid and an accepted beat coincide SHALL be attributed to the tag at the tag-line tail.
REQ-024 If the tail tag's settle_active bit is 0, the block SHALL register R_AXIS_tdata into M<ch>_AXIS_tdata and pulse M<ch>_AXIS_tvalid for one cycle; if it is 1, both M tvalid SHALL stay 0.
REQ-025 R_AXIS_tvalid without an accepted beat SHALL be ignored.
REQ-026 M tdata SHALL hold its value when tvalid is 0; data SHALL pass unmodified (no width change).
REQ-027 Result latency SHALL be one clock from the accepting edge to M tvalid.

Reset
REQ-028 When aresetn is low, the block SHALL immediately enter IDLE and clear grant, busy, counters, M tvalid and M tdata, and set last-served to 1 and all tags to settle_active=1.
REQ-029 Reset mid-burst SHALL abort the burst with no further M output; the first grant after release SHALL count as a switch.

Verification
REQ-030 Both channels idle after reset: S0 valid, cfg_burst=4 -> grant=0, 4 beats accepted, then a new CH0 grant.
REQ-031 Both channels held valid, cfg_burst=3 -> grants alternate CH0,CH1 (last-served=1 at reset) in 3-beat bursts.
REQ-032 SETTLE=6, PIPE_DEPTH=2, first burst on CH0 of 10 beats -> results 1-8 suppressed, M0 pulses for beats 9 and 10 carrying R_tdata.
REQ-033 cfg_burst=0 with both valid -> alternation every single beat and no M output (settle never expires).
REQ-034 D_AXIS_tready toggled 1/0 with S0 valid -> beats counted only when ready; R_tvalid in not-ready cycles ignored.
REQ-035 aresetn pulsed low mid-burst -> all outputs 0 in the same cycle; after release the next burst is treated as a switch (SETTLE results suppressed).

Source files
------------

// File: rtl/diff_scheduler.sv
// diff_scheduler: round-robin burst arbiter feeding two sample streams into one
// shared differentiator, steering the returned results back to per-channel
// outputs and masking the results polluted by a channel switch.
module diff_scheduler #(
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int PIPE_DEPTH       = 2,
  parameter int SETTLE           = 6
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        S0_AXIS_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] S0_AXIS_tdata,
  output logic                        S0_AXIS_tready,
  input  logic                        S1_AXIS_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] S1_AXIS_tdata,
  output logic                        S1_AXIS_tready,
  output logic                        D_AXIS_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] D_AXIS_tdata,
  input  logic                        D_AXIS_tready,
  input  logic                        R_AXIS_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] R_AXIS_tdata,
  output logic                        M0_AXIS_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] M0_AXIS_tdata,
  output logic                        M1_AXIS_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] M1_AXIS_tdata,
  input  logic [7:0]                  cfg_burst,
  output logic                        grant,
  output logic                        busy
);

  localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

  typedef enum logic [1:0] {IDLE, CH0, CH1} state_t;
  typedef struct packed {
    logic ch;
    logic active;   // result still inside the post-switch settle window
  } tag_t;

  state_t                  state;
  logic                    last_served;
  logic                    have_beat;
  logic                    last_beat_ch;
  logic [7:0]              beat_cnt;
  logic [SW-1:0]           settle_cnt;
  tag_t [PIPE_DEPTH-1:0]   tag_pipe;
  tag_t                    tail;

  logic       cur_ch, cur_v, oth_v, acc;
  logic       leave, do_grant, grant_ch;
  logic       prev_have, prev_ch, is_switch, res_ok;
  logic [8:0] limit;

  logic [1:0]                       m_vld;
  logic [1:0][AXIS_TDATA_WIDTH-1:0] m_data;

  assign cur_ch = (state == CH1);
  assign cur_v  = cur_ch ? S1_AXIS_tvalid : S0_AXIS_tvalid;
  assign oth_v  = cur_ch ? S0_AXIS_tvalid : S1_AXIS_tvalid;
  assign acc    = D_AXIS_tvalid & D_AXIS_tready;
  assign limit  = (cfg_burst == 8'd0) ? 9'd1 : {1'b0, cfg_burst};

  // Route the granted channel straight through to the differentiator
  always_comb begin
    S0_AXIS_tready = 1'b0;
    S1_AXIS_tready = 1'b0;
    D_AXIS_tvalid  = 1'b0;
    D_AXIS_tdata   = '0;
    case (state)
      CH0: begin
        D_AXIS_tvalid  = S0_AXIS_tvalid;
        D_AXIS_tdata   = S0_AXIS_tdata;
        S0_AXIS_tready = D_AXIS_tready;
      end
      CH1: begin
        D_AXIS_tvalid  = S1_AXIS_tvalid;
        D_AXIS_tdata   = S1_AXIS_tdata;
        S1_AXIS_tready = D_AXIS_tready;
      end
      default: ;
    endcase
  end

  // Grant decision: who gets the stream next and whether the current grant ends
  always_comb begin
    leave    = 1'b0;
    do_grant = 1'b0;
    grant_ch = 1'b0;
    if (state == IDLE) begin
      if (S0_AXIS_tvalid | S1_AXIS_tvalid) begin
        do_grant = 1'b1;
        grant_ch = (S0_AXIS_tvalid & S1_AXIS_tvalid) ? ~last_served : S1_AXIS_tvalid;
      end
    end else begin
      // >= so a limit lowered below the running count ends at the next beat
      leave = (acc && (({1'b0, beat_cnt} + 9'd1) >= limit)) || !cur_v;
      if (leave) begin
        if (oth_v) begin
          do_grant = 1'b1;
          grant_ch = ~cur_ch;
        end else if (cur_v) begin
          do_grant = 1'b1;
          grant_ch = cur_ch;
        end
      end
    end
  end

  // A beat accepted this cycle counts as the "previous beat" for a grant made now
  assign prev_have = have_beat | acc;
  assign prev_ch   = acc ? cur_ch : last_beat_ch;
  assign is_switch = do_grant & (~prev_have | (prev_ch != grant_ch));

  // Arbitration FSM with registered grant/busy
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      grant       <= 1'b0;
      busy        <= 1'b0;
      last_served <= 1'b1;
      beat_cnt    <= 8'd0;
    end else begin
      if (do_grant) begin
        state <= grant_ch ? CH1 : CH0;
        grant <= grant_ch;
        busy  <= 1'b1;
      end else if (leave) begin
        state <= IDLE;
        grant <= 1'b0;
        busy  <= 1'b0;
      end
      if (leave) begin
        last_served <= cur_ch;
        beat_cnt    <= 8'd0;
      end else if (acc) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
    end
  end

  // Settle window: reloaded on a channel switch, counted down by accepted beats
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      have_beat    <= 1'b0;
      last_beat_ch <= 1'b0;
      settle_cnt   <= '0;
    end else begin
      if (acc) begin
        have_beat    <= 1'b1;
        last_beat_ch <= cur_ch;
      end
      if (is_switch)
        settle_cnt <= SW'(SETTLE);
      else if (acc && (settle_cnt != '0))
        settle_cnt <= settle_cnt - SW'(1);
    end
  end

  // Tag line tracks which beat each returning result belongs to
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < PIPE_DEPTH; i++)
        tag_pipe[i] <= '{ch: 1'b0, active: 1'b1};
    end else if (acc) begin
      tag_pipe[0] <= '{ch: cur_ch, active: (settle_cnt != '0)};
      for (int i = 1; i < PIPE_DEPTH; i++)
        tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign tail   = tag_pipe[PIPE_DEPTH-1];
  assign res_ok = acc & R_AXIS_tvalid & ~tail.active;

  // Steer settled results to their channel output; data holds between pulses
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_vld  <= '0;
      m_data <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        m_vld[c] <= res_ok && (tail.ch == 1'(c));
        if (res_ok && (tail.ch == 1'(c)))
          m_data[c] <= R_AXIS_tdata;
      end
    end
  end

  assign M0_AXIS_tvalid = m_vld[0];
  assign M0_AXIS_tdata  = m_data[0];
  assign M1_AXIS_tvalid = m_vld[1];
  assign M1_AXIS_tdata  = m_data[1];

endmodule

// File: tb/tb_diff_scheduler.sv
// tb_diff_scheduler: table-driven per-cycle vectors for arbitration behaviour,
// plus hand-written sequences for the settle window and mid-burst reset.
module tb_diff_scheduler;
  localparam int W = 16;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic         s0v, s1v, s0r, s1r, dv, drdy, rv, m0v, m1v, grant, busy;
  logic [W-1:0] s0d, s1d, dd, rd, m0d, m1d;
  logic [7:0]   cfg;
  int           tests = 0;
  int           fails = 0;

  always #5 aclk = ~aclk;

  diff_scheduler #(.AXIS_TDATA_WIDTH(W), .PIPE_DEPTH(2), .SETTLE(6)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .S0_AXIS_tvalid(s0v), .S0_AXIS_tdata(s0d), .S0_AXIS_tready(s0r),
    .S1_AXIS_tvalid(s1v), .S1_AXIS_tdata(s1d), .S1_AXIS_tready(s1r),
    .D_AXIS_tvalid(dv), .D_AXIS_tdata(dd), .D_AXIS_tready(drdy),
    .R_AXIS_tvalid(rv), .R_AXIS_tdata(rd),
    .M0_AXIS_tvalid(m0v), .M0_AXIS_tdata(m0d),
    .M1_AXIS_tvalid(m1v), .M1_AXIS_tdata(m1d),
    .cfg_burst(cfg), .grant(grant), .busy(busy)
  );

  typedef struct {
    logic       s0v, s1v, drdy, rv;
    logic [7:0] cfg;
    logic       g, b, s0r, s1r, dv, m0v, m1v;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic a0, a1, ardy, arv, input logic [7:0] acfg,
                     input logic eg, eb, es0r, es1r, edv);
    vec_t v;
    v.s0v = a0; v.s1v = a1; v.drdy = ardy; v.rv = arv; v.cfg = acfg;
    v.g = eg; v.b = eb; v.s0r = es0r; v.s1r = es1r; v.dv = edv;
    v.m0v = 1'b0; v.m1v = 1'b0;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    s0v = 0; s1v = 0; drdy = 0; rv = 0; cfg = 0; s0d = 0; s1d = 0; rd = 0;
    repeat (2) @(posedge aclk);
    #1;
    chk("rst grant", grant, 0); chk("rst busy", busy, 0);
    chk("rst m0v", m0v, 0);     chk("rst m1v", m1v, 0);
    chk("rst m0d", m0d, 0);     chk("rst m1d", m1d, 0);
    chk("rst s0r", s0r, 0);     chk("rst s1r", s1r, 0);
    chk("rst dv", dv, 0);
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = tbl[i];
    @(negedge aclk);
    s0v = v.s0v; s1v = v.s1v; drdy = v.drdy; rv = v.rv; cfg = v.cfg;
    s0d = 16'hA000 + 16'(i); s1d = 16'hB000 + 16'(i); rd = 16'h7000 + 16'(i);
    #1;
    chk($sformatf("v%0d grant", i), grant, v.g);
    chk($sformatf("v%0d busy", i), busy, v.b);
    chk($sformatf("v%0d s0r", i), s0r, v.s0r);
    chk($sformatf("v%0d s1r", i), s1r, v.s1r);
    chk($sformatf("v%0d dv", i), dv, v.dv);
    if (v.dv) chk($sformatf("v%0d dtdata", i), dd, v.g ? s1d : s0d);
    @(posedge aclk);
    #1;
    chk($sformatf("v%0d m0v", i), m0v, v.m0v);
    chk($sformatf("v%0d m1v", i), m1v, v.m1v);
  endtask

  task automatic run_range(input int lo, input int hi);
    do_reset();
    for (int i = lo; i < hi; i++) run_vec(i);
  endtask

  // idle cycle with S0 raised: grant is issued at the following edge
  task automatic first_grant();
    @(negedge aclk);
    s0v = 1; s1v = 0; drdy = 1; rv = 1; cfg = 8'd20; rd = 16'h5EEE;
    #1;
    chk("fg busy", busy, 0); chk("fg dv", dv, 0);
    @(posedge aclk);
    #1;
    chk("fg m0v", m0v, 0);
  endtask

  task automatic beat(input int k, input logic rdy, input logic ev, input logic [15:0] ed);
    @(negedge aclk);
    s0v = 1; s1v = 0; cfg = 8'd20; drdy = rdy; rv = 1;
    rd = 16'h5000 + 16'(k); s0d = 16'h3000 + 16'(k);
    #1;
    chk($sformatf("b%0d dv", k), dv, 1);
    chk($sformatf("b%0d s0r", k), s0r, rdy);
    chk($sformatf("b%0d dtdata", k), dd, s0d);
    @(posedge aclk);
    #1;
    chk($sformatf("b%0d m0v", k), m0v, ev);
    chk($sformatf("b%0d m1v", k), m1v, 0);
    chk($sformatf("b%0d m0d", k), m0d, ed);
  endtask

  initial begin
    int p1, p2, p3, p4, p5, p6;
    // T1: S0 alone, burst of 4, then re-grant CH0, then S0 drops
    p1 = tbl.size();
    add(1,0,1,0,8'd4, 0,0,0,0,0);
    repeat (4) add(1,0,1,0,8'd4, 0,1,1,0,1);
    add(0,0,1,0,8'd4, 0,1,1,0,0);
    add(0,0,1,0,8'd4, 0,0,0,0,0);
    // T2: both valid, burst 3 -> CH0,CH1,CH0 alternation
    p2 = tbl.size();
    add(1,1,1,1,8'd3, 0,0,0,0,0);
    repeat (3) add(1,1,1,1,8'd3, 0,1,1,0,1);
    repeat (3) add(1,1,1,1,8'd3, 1,1,0,1,1);
    repeat (2) add(1,1,1,1,8'd3, 0,1,1,0,1);
    // T3: cfg_burst 0 behaves as 1 -> alternate every beat
    p3 = tbl.size();
    add(1,1,1,1,8'd0, 0,0,0,0,0);
    for (int k = 0; k < 6; k++)
      add(1,1,1,1,8'd0, k[0], 1, ~k[0], k[0], 1);
    // T4: ready toggling; only ready cycles count toward the burst of 3
    p4 = tbl.size();
    add(1,1,1,1,8'd3, 0,0,0,0,0);
    for (int k = 0; k < 6; k++)
      add(1,1,k[0],1,8'd3, 0,1,k[0],0,1);
    add(1,1,0,1,8'd3, 1,1,0,0,1);
    add(1,1,1,1,8'd3, 1,1,0,1,1);
    // T5: limit lowered below running count ends the grant at the next beat
    p5 = tbl.size();
    add(1,1,1,0,8'd8, 0,0,0,0,0);
    repeat (3) add(1,1,1,0,8'd8, 0,1,1,0,1);
    add(1,1,1,0,8'd2, 0,1,1,0,1);
    add(1,1,1,0,8'd2, 1,1,0,1,1);
    p6 = tbl.size();

    run_range(p1, p2);
    run_range(p2, p3);
    run_range(p3, p4);
    run_range(p4, p5);
    run_range(p5, p6);

    // Settle window: beats 1-8 suppressed, results with beats 9 and 10 emerge
    do_reset();
    first_grant();
    for (int k = 1; k <= 9; k++)
      beat(k, 1'b1, k == 9, (k == 9) ? 16'h5009 : 16'h0000);
    beat(99, 1'b0, 1'b0, 16'h5009);   // not ready: result ignored, data held
    beat(10, 1'b1, 1'b1, 16'h500A);

    // Reset mid-burst clears outputs asynchronously
    #2;
    aresetn = 1'b0;
    #1;
    chk("mid m0v", m0v, 0);   chk("mid m0d", m0d, 0);
    chk("mid m1v", m1v, 0);   chk("mid grant", grant, 0);
    chk("mid busy", busy, 0); chk("mid dv", dv, 0);
    chk("mid s0r", s0r, 0);
    @(posedge aclk);
    @(negedge aclk);
    s0v = 0; rv = 0;
    aresetn = 1'b1;

    // First burst after reset is a switch: settle window applies again
    first_grant();
    for (int k = 1; k <= 10; k++)
      beat(k, 1'b1, k >= 9, (k >= 9) ? (16'h5000 + 16'(k)) : 16'h0000);

    @(negedge aclk);
    s0v = 0; s1v = 0; rv = 0;
    repeat (2) @(posedge aclk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
